program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_pkg.sv | 27 ++
 rtl/program_sequencer_return_stack.sv | 50 +++++
 rtl/program_sequencer.sv | 92 +++++++++
 tb/tb_program_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared command encoding and sizing helpers for the program sequencer and its return stack.
package program_sequencer_pkg;

    // One action per enabled cycle, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        CMD_INC    = 3'd0,
        CMD_BRANCH = 3'd1,
        CMD_LOAD   = 3'd2,
        CMD_RET    = 3'd3,
        CMD_CALL   = 3'd4
    } cmd_e;

    // Width needed to count 0..entries inclusive.
    function automatic int depth_width(input int entries);
        return $clog2(entries + 1);
    endfunction

    function automatic cmd_e encode_cmd(input logic call, input logic ret,
                                        input logic load, input logic branch);
        if (call)        return CMD_CALL;
        else if (ret)    return CMD_RET;
        else if (load)   return CMD_LOAD;
        else if (branch) return CMD_BRANCH;
        else             return CMD_INC;
    endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses; depth counts valid entries, data_out shows the top entry.
module return_stack
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [ADDR_WIDTH-1:0]                data_in,
    output logic [ADDR_WIDTH-1:0]                data_out,
    output logic [depth_width(STACK_DEPTH)-1:0]  depth
);

    localparam int DW = depth_width(STACK_DEPTH);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] mem [2**IW];
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic                  can_push;
    logic                  can_pop;

    assign can_push = push && (depth != DW'(STACK_DEPTH));
    assign can_pop  = pop && !push && (depth != '0);
    assign wr_idx   = IW'(depth);
    assign rd_idx   = IW'(depth - DW'(1));
    assign data_out = mem[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
        end else if (can_push) begin
            depth <= depth + DW'(1);
        end else if (can_pop) begin
            depth <= depth - DW'(1);
        end
    end

    // NOTE: the storage array has no reset; depth alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (can_push) begin
            mem[wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with load, relative branch, call/return via a return stack, and sticky stack errors.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                     ADDR_WIDTH   = 12,
    parameter int                     STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 load,
    input  logic [ADDR_WIDTH-1:0]                pre_load,
    input  logic                                 branch,
    input  logic [ADDR_WIDTH-1:0]                offset,
    input  logic                                 call,
    input  logic                                 ret,
    input  logic                                 clear_err,
    output logic [ADDR_WIDTH-1:0]                value,
    output logic [depth_width(STACK_DEPTH)-1:0]  depth,
    output logic                                 stack_full,
    output logic                                 stack_empty,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int DW = depth_width(STACK_DEPTH);

    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] value_inc;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  push;
    logic                  pop;

    assign cmd         = encode_cmd(call, ret, load, branch);
    assign value_inc   = value + ADDR_WIDTH'(1);
    assign stack_full  = (depth == DW'(STACK_DEPTH));
    assign stack_empty = (depth == '0);
    assign push        = enable && (cmd == CMD_CALL) && !stack_full;
    assign pop         = enable && (cmd == CMD_RET) && !stack_empty;

    return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (value_inc),
        .data_out (stack_top),
        .depth    (depth)
    );

    // clear_err acts even when disabled; a new error later in the block overrides the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value     <= RESET_VECTOR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clear_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (enable) begin
                unique case (cmd)
                    CMD_CALL: begin
                        if (stack_full) begin
                            value    <= value_inc;
                            overflow <= 1'b1;
                        end else begin
                            value <= pre_load;
                        end
                    end
                    CMD_RET: begin
                        if (stack_empty) begin
                            value     <= value_inc;
                            underflow <= 1'b1;
                        end else begin
                            value <= stack_top;
                        end
                    end
                    CMD_LOAD:   value <= pre_load;
                    CMD_BRANCH: value <= value + offset;
                    default:    value <= value_inc;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed-vector bench for program_sequencer with hand-computed expected values.
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [11:0] pre_load;
    logic        branch;
    logic [11:0] offset;
    logic        call;
    logic        ret;
    logic        clear_err;
    logic [11:0] value;
    logic [2:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    program_sequencer #(
        .ADDR_WIDTH   (12),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (12'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .pre_load    (pre_load),
        .branch      (branch),
        .offset      (offset),
        .call        (call),
        .ret         (ret),
        .clear_err   (clear_err),
        .value       (value),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cmds();
        load = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; clear_err = 1'b0;
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; pre_load = '0; offset = '0;
        idle_cmds();

        #1;
        check("rst_value", value, 0);
        check("rst_depth", depth, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        tick();
        reset = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("count_%0d", i), value, i);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", value, 16);
        end

        // Absolute load then increment; wrap at the top of the address space.
        enable = 1'b1; load = 1'b1; pre_load = 12'd15;
        tick(); check("load15", value, 15);
        load = 1'b0;
        tick(); check("load15_inc", value, 16);
        load = 1'b1; pre_load = 12'd4095;
        tick(); check("load_max", value, 4095);
        load = 1'b0;
        tick(); check("wrap", value, 0);

        // Relative branches backwards and forwards.
        load = 1'b1; pre_load = 12'd100;
        tick(); check("load100", value, 100);
        load = 1'b0; branch = 1'b1; offset = 12'hFFC;
        tick(); check("branch_neg", value, 96);
        offset = 12'd8;
        tick(); check("branch_pos", value, 104);
        branch = 1'b0;

        // Call / return and underflow.
        load = 1'b1; pre_load = 12'd10;
        tick(); check("load10", value, 10);
        load = 1'b0; call = 1'b1; pre_load = 12'd200;
        tick(); check("call_val", value, 200); check("call_depth", depth, 1);
        check("call_not_empty", stack_empty, 0);
        call = 1'b0; ret = 1'b1;
        tick(); check("ret_val", value, 11); check("ret_depth", depth, 0);
        tick(); check("unf_val", value, 12); check("unf_flag", underflow, 1);
        ret = 1'b0; enable = 1'b0; clear_err = 1'b1;
        tick(); check("clr_unf", underflow, 0); check("clr_hold", value, 12);
        clear_err = 1'b0; enable = 1'b1;

        // Fill the stack, then overflow.
        call = 1'b1;
        pre_load = 12'd300; tick(); check("nest1", value, 300);
        pre_load = 12'd400; tick(); check("nest2", value, 400);
        pre_load = 12'd500; tick(); check("nest3", value, 500);
        pre_load = 12'd600; tick(); check("nest4", value, 600);
        check("nest_depth", depth, 4); check("nest_full", stack_full, 1);
        check("nest_no_ovf", overflow, 0);
        pre_load = 12'd700; tick();
        check("ovf_val", value, 601); check("ovf_flag", overflow, 1);
        check("ovf_depth", depth, 4);
        call = 1'b0; ret = 1'b1;
        tick(); check("pop_top", value, 501); check("pop_depth", depth, 3);
        ret = 1'b0; clear_err = 1'b1;
        tick(); check("clr_ovf", overflow, 0); check("clr_inc", value, 502);
        clear_err = 1'b0; ret = 1'b1;
        tick(); check("pop2", value, 401); check("pop2_depth", depth, 2);

        // call beats ret when both are asserted.
        call = 1'b1; pre_load = 12'd800;
        tick(); check("call_wins", value, 800); check("call_wins_depth", depth, 3);
        idle_cmds();

        // Asynchronous reset mid-cycle with a non-empty stack.
        #3 reset = 1'b0;
        #1;
        check("async_val", value, 0); check("async_depth", depth, 0);
        check("async_empty", stack_empty, 1);
        tick();
        reset = 1'b1;

        // First edge after release: ret finds no stale return; error beats same-cycle clear.
        ret = 1'b1; clear_err = 1'b1;
        tick();
        check("post_rst_val", value, 1); check("post_rst_unf", underflow, 1);
        ret = 1'b0;
        tick(); check("post_rst_clr", underflow, 0); check("post_rst_inc", value, 2);
        idle_cmds();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
